// File: rtl/alsu_seq.sv
// alsu_seq -- handshaked arithmetic/logic/shift unit with a 2*WIDTH-bit
// registered result.
//
// One operation is accepted per valid/ready transfer (only while IDLE). All
// operands and modifiers are captured into *_reg on the accepting edge and
// the operation executes from those registers, so the inputs are free to
// change afterwards.
//
// Build option:
//   ALSU_MUL_SEQ_EN  defined   -> MUL runs in a dedicated state as a
//                                 WIDTH-cycle shift-add (no multiplier array)
//                    undefined -> MUL is a single-cycle A*B in EXEC
//
// Parameters:
//   WIDTH           operand width (>= 2); result width is 2*WIDTH
//   INPUT_PRIORITY  "A" or "B": operand chosen when both bypass flags or
//                   both reduction flags are set
//   FULL_ADDER      "ON" adds cin to ADD, "OFF" ignores it
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   in_valid         operation request
//   in_ready         high only in IDLE
//   A, B             operands
//   opcode           000 AND, 001 XOR, 010 ADD, 011 MUL, 100 SHIFT,
//                    101 ROTATE, 110/111 invalid
//   cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B
//                    operation modifiers
//   out              registered result, held until the next completion
//   out_valid        one-cycle pulse when out is written
//   invalid          one-cycle pulse with out_valid for an invalid operation
//   busy             high while executing (EXEC or MUL)
//   leds             all bits inverted on every invalid completion
module alsu_seq #(
  parameter int unsigned WIDTH          = 8,
  parameter string       INPUT_PRIORITY = "A",
  parameter string       FULL_ADDER     = "ON"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           opcode,
  input  logic                 cin,
  input  logic                 serial_in,
  input  logic                 direction,
  input  logic                 red_op_A,
  input  logic                 red_op_B,
  input  logic                 bypass_A,
  input  logic                 bypass_B,
  output logic [2*WIDTH-1:0]   out,
  output logic                 out_valid,
  output logic                 invalid,
  output logic                 busy,
  output logic [15:0]          leds
);

  localparam int unsigned W2 = 2 * WIDTH;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_XOR   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_SHIFT = 3'b100;
  localparam logic [2:0] OP_ROT   = 3'b101;

  localparam bit PRIO_A  = (INPUT_PRIORITY != "B");
  localparam bit ADD_CIN = (FULL_ADDER == "ON");

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1
`ifdef ALSU_MUL_SEQ_EN
    ,
    MUL  = 2'd2
`endif
  } state_t;

  state_t state;

  logic [WIDTH-1:0] A_reg;
  logic [WIDTH-1:0] B_reg;
  logic [2:0]       opcode_reg;
  logic             cin_reg;
  logic             serial_in_reg;
  logic             direction_reg;
  logic             red_op_A_reg;
  logic             red_op_B_reg;
  logic             bypass_A_reg;
  logic             bypass_B_reg;

  logic             inv_op;
  logic             use_red_a;
  logic             use_red_b;
  logic [WIDTH:0]   sum;
  logic [W2-1:0]    res;

`ifdef ALSU_MUL_SEQ_EN
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    mcand;
  logic [W2-1:0]    acc_sum;

  // mcand holds A_reg << cnt, so each step only needs a conditional add.
  always_comb begin
    acc_sum = acc;
    if (B_reg[cnt]) begin
      acc_sum = acc + mcand;
    end
  end
`else
  logic [W2-1:0]    prod;

  always_comb begin
    prod = {{WIDTH{1'b0}}, A_reg} * {{WIDTH{1'b0}}, B_reg};
  end
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Result of a single-cycle operation, evaluated from the captured registers.
  always_comb begin
    inv_op    = (opcode_reg[2:1] == 2'b11) ||
                ((red_op_A_reg || red_op_B_reg) && (opcode_reg[2:1] != 2'b00));
    use_red_a = red_op_A_reg && (!red_op_B_reg || PRIO_A);
    use_red_b = red_op_B_reg && (!red_op_A_reg || !PRIO_A);
    sum       = {1'b0, A_reg} + {1'b0, B_reg} +
                {{WIDTH{1'b0}}, (cin_reg & ADD_CIN)};
    res       = '0;

    if (bypass_A_reg || bypass_B_reg) begin
      if (bypass_A_reg && (!bypass_B_reg || PRIO_A)) begin
        res[WIDTH-1:0] = A_reg;
      end else begin
        res[WIDTH-1:0] = B_reg;
      end
    end else if (!inv_op) begin
      case (opcode_reg)
        OP_AND: begin
          if (use_red_a) begin
            res[0] = &A_reg;
          end else if (use_red_b) begin
            res[0] = &B_reg;
          end else begin
            res[WIDTH-1:0] = A_reg & B_reg;
          end
        end
        OP_XOR: begin
          if (use_red_a) begin
            res[0] = ^A_reg;
          end else if (use_red_b) begin
            res[0] = ^B_reg;
          end else begin
            res[WIDTH-1:0] = A_reg ^ B_reg;
          end
        end
        OP_ADD: begin
          res[WIDTH:0] = sum;
        end
        OP_MUL: begin
`ifndef ALSU_MUL_SEQ_EN
          res = prod;
`endif
        end
        OP_SHIFT: begin
          if (direction_reg) begin
            res = {out[W2-2:0], serial_in_reg};
          end else begin
            res = {serial_in_reg, out[W2-1:1]};
          end
        end
        OP_ROT: begin
          if (direction_reg) begin
            res = {out[W2-2:0], out[W2-1]};
          end else begin
            res = {out[0], out[W2-1:1]};
          end
        end
        default: begin
          res = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      A_reg         <= '0;
      B_reg         <= '0;
      opcode_reg    <= '0;
      cin_reg       <= 1'b0;
      serial_in_reg <= 1'b0;
      direction_reg <= 1'b0;
      red_op_A_reg  <= 1'b0;
      red_op_B_reg  <= 1'b0;
      bypass_A_reg  <= 1'b0;
      bypass_B_reg  <= 1'b0;
      out           <= '0;
      out_valid     <= 1'b0;
      invalid       <= 1'b0;
      leds          <= '0;
`ifdef ALSU_MUL_SEQ_EN
      cnt           <= '0;
      acc           <= '0;
      mcand         <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      invalid   <= 1'b0;

      case (state)
        IDLE: begin
          if (in_valid) begin
            A_reg         <= A;
            B_reg         <= B;
            opcode_reg    <= opcode;
            cin_reg       <= cin;
            serial_in_reg <= serial_in;
            direction_reg <= direction;
            red_op_A_reg  <= red_op_A;
            red_op_B_reg  <= red_op_B;
            bypass_A_reg  <= bypass_A;
            bypass_B_reg  <= bypass_B;
`ifdef ALSU_MUL_SEQ_EN
            // Only a genuine multiply goes through the shift-add path; a
            // bypassed or invalid MUL opcode completes in EXEC instead.
            if ((opcode == OP_MUL) && !bypass_A && !bypass_B &&
                !red_op_A && !red_op_B) begin
              state <= MUL;
              cnt   <= '0;
              acc   <= '0;
              mcand <= {{WIDTH{1'b0}}, A};
            end else begin
              state <= EXEC;
            end
`else
            state <= EXEC;
`endif
          end
        end

        EXEC: begin
          out       <= res;
          out_valid <= 1'b1;
          invalid   <= inv_op;
          if (inv_op) begin
            leds <= ~leds;
          end
          state <= IDLE;
        end

`ifdef ALSU_MUL_SEQ_EN
        MUL: begin
          if (cnt == CNT_LAST) begin
            out       <= acc_sum;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            acc   <= acc_sum;
            mcand <= mcand << 1;
            cnt   <= cnt + 1'b1;
          end
        end
`endif

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
